// File: rtl/score_display_scan_pkg.sv
// Shared display constants for the score display scanner.
//   SEG_BLANK   : all segments off (active-low)
//   SEG_DASH    : only segment g lit, shown for non-decimal nibbles
//   SEG_TABLE   : active-low {g,f,e,d,c,b,a} patterns for digits 0..9
//   DIGIT_IDX_W : width of the digit-slot index
package score_display_scan_pkg;

    localparam int unsigned DIGIT_IDX_W = 2;
    localparam int unsigned NUM_DIGITS  = 4;
    localparam int unsigned SEG_W       = 7;
    localparam int unsigned BCD_W       = 4;
    localparam int unsigned SCORE_W     = NUM_DIGITS * BCD_W;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'h3F;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

    // Entry [d] is the pattern for decimal digit d.
    localparam logic [9:0][SEG_W-1:0] SEG_TABLE = {
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

endpackage

// File: rtl/score_display_scan_bcd_to_seg.sv
// Combinational nibble to 7-segment decoder.
//   bcd   : 4-bit digit value
//   seg_n : active-low {g,f,e,d,c,b,a}; 10..15 decode to a dash
module bcd_to_seg
    import score_display_scan_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [SEG_W-1:0] seg_n
);

    always_comb begin
        seg_n = SEG_DASH;
        if (bcd <= 4'd9) begin
            seg_n = SEG_TABLE[bcd];
        end
    end

endmodule

// File: rtl/score_display_scan.sv
// Time-multiplexed 4-digit score display driver with leading-zero blanking.
//   clk       : clock
//   rst_n     : asynchronous active-low reset
//   load      : strobe capturing score_bcd into the snapshot
//   score_bcd : packed BCD {thousand,hundred,ten,one}
//   seg_n     : registered active-low segments {g,f,e,d,c,b,a}
//   an_n      : registered active-low digit enables, bit0 = ones
module score_display_scan
    import score_display_scan_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [SCORE_W-1:0]    score_bcd,
    output logic [SEG_W-1:0]      seg_n,
    output logic [NUM_DIGITS-1:0] an_n
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CNT_W-1:0]       r_cnt;
    logic [DIGIT_IDX_W-1:0] r_idx;
    logic [SCORE_W-1:0]     r_snap;
    logic [SEG_W-1:0]       r_seg_n;
    logic [NUM_DIGITS-1:0]  r_an_n;

    logic                   w_tick;
    logic [BCD_W-1:0]       w_nibble;
    logic                   w_blank;
    logic [SEG_W-1:0]       w_dec_seg_n;
    logic [NUM_DIGITS-1:0]  w_an_n;

    assign w_tick = (r_cnt == CNT_W'(SCAN_DIV - 1));

    // Digit select and leading-zero test: a slot is blank only when it and
    // every more significant nibble are zero; dashes are non-zero so they
    // never blank, and the ones slot always shows.
    always_comb begin
        w_nibble = r_snap[3:0];
        w_blank  = 1'b0;
        case (r_idx)
            2'd0: begin
                w_nibble = r_snap[3:0];
                w_blank  = 1'b0;
            end
            2'd1: begin
                w_nibble = r_snap[7:4];
                w_blank  = (r_snap[15:4] == 12'h000);
            end
            2'd2: begin
                w_nibble = r_snap[11:8];
                w_blank  = (r_snap[15:8] == 8'h00);
            end
            default: begin
                w_nibble = r_snap[15:12];
                w_blank  = (r_snap[15:12] == 4'h0);
            end
        endcase
    end

    assign w_an_n = ~(4'b0001 << r_idx);

    bcd_to_seg u_bcd_to_seg (
        .bcd   (w_nibble),
        .seg_n (w_dec_seg_n)
    );

    // Scan divider and digit index; index wraps naturally at 3.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
            r_idx <= r_idx + DIGIT_IDX_W'(1);
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Score snapshot, independent of scan position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap <= '0;
        end else if (load) begin
            r_snap <= score_bcd;
        end
    end

    // Output registers follow the current index/snapshot one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_n <= SEG_BLANK;
            r_an_n  <= AN_OFF;
        end else if (w_blank) begin
            r_seg_n <= SEG_BLANK;
            r_an_n  <= AN_OFF;
        end else begin
            r_seg_n <= w_dec_seg_n;
            r_an_n  <= w_an_n;
        end
    end

    assign seg_n = r_seg_n;
    assign an_n  = r_an_n;

endmodule

// File: tb/tb_score_display_scan.sv
module tb_score_display_scan;

    localparam int SCAN_DIV = 4;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] score_bcd;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;

    int checks = 0;
    int errors = 0;

    // Reference state: edges since reset release and the latched score.
    int          m_cycles;
    logic [15:0] m_snap;

    int seg_lut[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                        7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    score_display_scan #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .score_bcd (score_bcd),
        .seg_n     (seg_n),
        .an_n      (an_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {an_n, seg_n} for a given scan position and score.
    function automatic logic [10:0] model_out(input int cyc, input logic [15:0] snap);
        int idx;
        int nib;
        int ndisp;
        logic [3:0] an;
        logic [6:0] seg;
        idx   = (cyc / SCAN_DIV) % 4;
        nib   = (snap >> (4 * idx)) & 15;
        ndisp = 1;
        for (int k = 0; k < 4; k++) begin
            if (((snap >> (4 * k)) & 16'hF) != 0) ndisp = k + 1;
        end
        if (idx >= ndisp) return {4'b1111, 7'h7F};
        seg = (nib > 9) ? 7'h3F : 7'(seg_lut[nib]);
        an  = 4'(~(1 << idx));
        return {an, seg};
    endfunction

    task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed an_n=%b seg_n=%h expected an_n=%b seg_n=%h",
                   tag, obs[10:7], obs[6:0], exp[10:7], exp[6:0]);
        end
    endtask

    task automatic step(input string tag, input logic ld, input logic [15:0] val);
        logic [10:0] exp;
        load      = ld;
        score_bcd = val;
        exp       = model_out(m_cycles, m_snap);
        @(posedge clk);
        #1;
        if (ld) m_snap = val;
        m_cycles++;
        load = 1'b0;
        check(tag, {an_n, seg_n}, exp);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 16'h0);
    endtask

    // Step until the scan counter sits at the given phase of its slot.
    task automatic run_to_phase(input string tag, input int ph);
        for (int i = 0; i < SCAN_DIV && (m_cycles % SCAN_DIV) != ph; i++)
            step(tag, 1'b0, 16'h0);
    endtask

    function automatic logic [15:0] rand_score();
        logic [15:0] v;
        for (int k = 0; k < 4; k++) begin
            v[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        end
        return v;
    endfunction

    initial begin
        rst_n     = 1'b0;
        load      = 1'b0;
        score_bcd = 16'h0;
        m_cycles  = 0;
        m_snap    = 16'h0;

        #12;
        check("reset_hold", {an_n, seg_n}, {4'b1111, 7'h7F});
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        m_cycles = 1;
        check("reset_first_edge", {an_n, seg_n}, {4'b1110, 7'h40});
        idle("reset_scan", 4);
        check("reset_ten_blank", {an_n, seg_n}, {4'b1111, 7'h7F});
        idle("reset_scan", 11);

        // Full scan of 1234 starting at slot 0.
        run_to_phase("align", 0);
        step("load_1234", 1'b1, 16'h1234);
        idle("scan_1234", 4 * SCAN_DIV);

        step("load_0050", 1'b1, 16'h0050);
        idle("scan_0050", 4 * SCAN_DIV + 2);

        step("load_0A07", 1'b1, 16'h0A07);
        idle("scan_0A07", 4 * SCAN_DIV + 1);

        // Load landing on the tick edge, then in the middle of a slot.
        run_to_phase("align", SCAN_DIV - 1);
        step("load_on_tick", 1'b1, 16'h8765);
        idle("after_tick_load", SCAN_DIV + 1);
        run_to_phase("align", 1);
        step("load_mid_slot", 1'b1, 16'h0309);
        idle("after_mid_load", 2 * SCAN_DIV);

        // Random loads at random points of the scan.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) step("rand_load", 1'b1, rand_score());
            else step("rand_run", 1'b0, 16'($urandom));
        end

        // Mid-slot reset with 9999 on the display.
        step("load_9999", 1'b1, 16'h9999);
        run_to_phase("align", 2);
        idle("pre_reset", 1);
        rst_n = 1'b0;
        #2;
        check("reset_midslot_async", {an_n, seg_n}, {4'b1111, 7'h7F});
        #2;
        rst_n    = 1'b1;
        m_cycles = 0;
        m_snap   = 16'h0;
        idle("after_reset", 4 * SCAN_DIV + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/score_display_scan.md
SCORE_DISPLAY_SCAN -- requirements
Module: score_display_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clk cycles each digit slot is held; legal range 2..2^20.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port load  input  1  one-cycle strobe; captures score_bcd into the snapshot register.
REQ-005 SHALL have port score_bcd  input  16  4-digit packed BCD {thousand,hundred,ten,one}, as produced by the score accumulator.
REQ-006 SHALL have port seg_n  output  7  active-low segments {g,f,e,d,c,b,a}; registered.
REQ-007 SHALL have port an_n  output  4  active-low digit enables, bit0 = ones digit; registered.

Function
REQ-008 SHALL hold a 16-bit snapshot register; on an edge with load=1, snapshot <= score_bcd; otherwise it holds.
REQ-009 SHALL run a divider counter 0..SCAN_DIV-1 that wraps to 0; terminal count = tick.
REQ-010 SHALL advance a 2-bit digit index 0->1->2->3->0 on the same edge as each tick; index never resets except on rst_n.
REQ-011 SHALL register outputs from the current (index, snapshot): outputs change one cycle after index or snapshot changes.
REQ-012 SHALL select nibble snapshot[4*idx+3 : 4*idx] for digit idx.
REQ-013 SHALL drive an_n = ~(4'b0001 << idx) for a displayed digit, and an_n = 4'b1111, seg_n = 7'h7F for a blanked digit.
REQ-014 SHALL decode 0..9 to standard 7-segment patterns (0 -> 7'h40, 1 -> 7'h79, 8 -> 7'h00).
REQ-015 SHALL decode any nibble 10..15 to dash (g only, seg_n = 7'h3F) and SHALL exempt it from blanking.
REQ-016 SHALL blank leading zeros: thousand blanked if 0; hundred if thousand and hundred are 0; ten if thousand, hundred and ten are 0; ones never blanked.
REQ-017 SHALL allow load at any point in the scan; no counter or index disturbance, new value visible from the next output update.
REQ-018 SHALL, when load coincides with tick, use the new index with the new snapshot on the following output update.

Reset
REQ-019 SHALL, while rst_n=0, force counter=0, idx=0, snapshot=16'h0000, an_n=4'b1111, seg_n=7'h7F, independent of clk.
REQ-020 SHALL, on the first rising edge after rst_n deasserts, present digit 0 of snapshot 0: an_n=4'b1110, seg_n=7'h40.
REQ-021 SHALL, on reset mid-scan, abandon the scan and restart from digit 0 with the snapshot cleared.

Structure
REQ-022 SHALL put SEG_BLANK (7'h7F), SEG_DASH (7'h3F), the 0..9 segment table and DIGIT_IDX_W (2) in a shared display package.
REQ-023 SHALL implement nibble-to-segment decoding in one combinational sub-module, bcd_to_seg (4-bit in, 7-bit active-low out).
REQ-024 SHALL keep all state (counter, idx, snapshot, output registers) in score_display_scan.

Verification (SCAN_DIV=4)
REQ-025 SHALL cover reset release: after 1 edge, an_n=1110, seg_n=7'h40; after 4 more edges, an_n=1111 (ten blanked).
REQ-026 SHALL cover load score_bcd=16'h1234 then a full scan: an_n sequence 1110,1101,1011,0111 with seg_n for 4,3,2,1, each slot held 4 cycles.
REQ-027 SHALL cover score_bcd=16'h0050: thousand and hundred slots blank (an_n=1111), ten shows 5, ones shows 0 (7'h40).
REQ-028 SHALL cover score_bcd=16'h0A07: thousand blank, hundred shows dash 7'h3F, ten shows 0, ones shows 7.
REQ-029 SHALL cover load coinciding with tick and load mid-slot: no change in slot timing, new digit pattern one cycle later.
REQ-030 SHALL cover rst_n asserted mid-slot with 16'h9999 loaded: outputs go 1111/7F immediately, snapshot reads 0 after release.
